fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
Pointer and flag controller for the UART TX/RX FIFOs. It pairs with the 2**ADDR_WIDTH x DATA_BITS register-file storage, which has a synchronous write and an asynchronous read. The block generates the write enable, write address and read address, and tracks occupancy. The push/pop interface sits toward the UART core and the host, and reads are first-word-fall-through.

Parameters:
ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH (32 entries)
AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL (range 1..DEPTH)
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (range 0..DEPTH-1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
wr  in  1  push request; data presented to storage in the same cycle
rd  in  1  pop request; consumes the word currently at r_addr
w_en  out  1  storage write enable = wr & ~full (combinational)
w_addr  out  ADDR_WIDTH  storage write address (write pointer)
r_addr  out  ADDR_WIDTH  storage read address (read pointer)
full  out  1  DEPTH words held
empty  out  1  zero words held
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: wr while full
underflow  out  1  one-cycle pulse: rd while empty

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Reset dominates wr/rd in the same cycle and aborts any operation mid-stream.
  - Storage contents are not cleared.
- Effective operations:
  - do_wr = wr & ~full
  - do_rd = rd & ~empty
  - All state updates at posedge clk use these.
- Pointers:
  - wptr += do_wr; rptr += do_rd.
  - Modulo-DEPTH natural wrap (31 -> 0); no extra wrap bit.
  - full and empty are resolved from count.
- count update, by (do_wr, do_rd):
  - 10: +1
  - 01: -1
  - 11: unchanged
  - 00: unchanged
- Flags:
  - full, empty, almost_full and almost_empty are registered.
  - They are computed from next-count so they agree with count in the same cycle.
  - full == (count==DEPTH); empty == (count==0).
- Simultaneous wr and rd:
  - Not full and not empty: both pointers advance, count holds.
  - Empty: write only; rd flagged as underflow; next cycle empty=0, count=1.
  - Full: read only; wr flagged as overflow (w_en=0); next cycle full=0, count=DEPTH-1.
- Read timing (FWFT):
  - When empty=0, the storage's r_data (indexed by r_addr) is the head word, valid combinationally.
  - rd pops it; the next word appears after the clock edge.
  - A word written at edge N is readable after edge N (empty deasserts same edge): write-to-read latency 1 cycle.
- Error pulses:
  - overflow and underflow are registered, high for exactly one cycle after the offending request.
  - They cause no state change.
- Outputs w_addr/r_addr are the pointer registers directly (no extra latency).

Decomposition:
- Package fifo_pkg holds:
  - default ADDR_WIDTH/DATA_BITS constants
  - a typedef for the (do_wr, do_rd) operation encoding (enum: NOP, PUSH, POP, PUSH_POP)
- No sub-module required.
- The top-level FIFO wrapper instantiates fifo_ctrl alongside the register-file storage and wires w_en/w_addr/r_addr.

Test Plan:
- Reset, then idle → empty=1, full=0, count=0, w_addr=r_addr=0, almost_empty=1.
- 32 consecutive pushes of 0x000..0x01F →
  - almost_full rises on the cycle count becomes 28.
  - full=1 at count=32; w_addr wraps to 0.
  - 33rd push → w_en=0, overflow pulse, count stays 32.
- Full, then 32 pops → head data sequence 0x000..0x01F in order; empty=1 after the last pop; 33rd rd → underflow pulse, r_addr unchanged.
- Simultaneous wr+rd:
  - At count=5: count stays 5, both pointers +1.
  - At empty: count→1, underflow pulse.
  - At full: count→31, overflow pulse, no write.
- Pointer wrap under steady stream: preload 3 words, then 100 cycles of wr+rd with an incrementing pattern → count constant 3, read data equals write data delayed by 3 pops, pointers wrap cleanly.
- rst_n low mid-burst (count=17, wr=rd=1 asserted) → next cycle all outputs at reset values; first push after reset lands at address 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and the operation encoding for the UART FIFO pointer controller.
// Imported by the controller and its bus interface.
package fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_BITS_DEF  = 8;

    // Bit order matches {do_wr, do_rd} so the operation is a direct cast.
    typedef enum logic [1:0] {
        NOP      = 2'b00,
        POP      = 2'b01,
        PUSH     = 2'b10,
        PUSH_POP = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Push/pop, storage-addressing and status bundle between the FIFO controller and its users.
// The master drives requests; the slave (the controller) drives everything else.
interface fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  wr;
    logic                  rd;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, rd,
        input  w_en, w_addr, r_addr, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, rd,
        output w_en, w_addr, r_addr, full, empty,
               almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a register-file FIFO with async read (FWFT).
// Flags are registered but derived from next-count, so they always agree with count.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int AF_LEVEL   = 28,
    parameter int AE_LEVEL   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    fifo_ctrl_if.slave bus
);
    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wptr_reg,  wptr_next;
    logic [ADDR_WIDTH-1:0] rptr_reg,  rptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  full_reg, empty_reg, af_reg, ae_reg;
    logic                  overflow_reg, underflow_reg;
    logic                  do_wr, do_rd;
    fifo_op_e              op;

    assign do_wr = bus.wr & ~full_reg;
    assign do_rd = bus.rd & ~empty_reg;
    assign op    = fifo_op_e'({do_wr, do_rd});

    always_comb begin
        wptr_next  = wptr_reg;
        rptr_next  = rptr_reg;
        count_next = count_reg;
        // Pointers wrap naturally at DEPTH; full/empty come from count, not pointer compare.
        unique case (op)
            PUSH: begin
                wptr_next  = wptr_reg + 1'b1;
                count_next = count_reg + 1'b1;
            end
            POP: begin
                rptr_next  = rptr_reg + 1'b1;
                count_next = count_reg - 1'b1;
            end
            PUSH_POP: begin
                wptr_next = wptr_reg + 1'b1;
                rptr_next = rptr_reg + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            af_reg        <= 1'b0;
            ae_reg        <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            count_reg     <= count_next;
            full_reg      <= (count_next == DEPTH_C);
            empty_reg     <= (count_next == '0);
            af_reg        <= (count_next >= AF_C);
            ae_reg        <= (count_next <= AE_C);
            overflow_reg  <= bus.wr & full_reg;
            underflow_reg <= bus.rd & empty_reg;
        end
    end

    assign bus.w_en         = do_wr;
    assign bus.w_addr       = wptr_reg;
    assign bus.r_addr       = rptr_reg;
    assign bus.count        = count_reg;
    assign bus.full         = full_reg;
    assign bus.empty        = empty_reg;
    assign bus.almost_full  = af_reg;
    assign bus.almost_empty = ae_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural register-file storage alongside it.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] w_data = '0;
    logic [7:0] r_data;
    logic [7:0] mem [32];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    fifo_ctrl_if #(.ADDR_WIDTH(5)) bus ();

    fifo_ctrl #(
        .ADDR_WIDTH (5),
        .AF_LEVEL   (28),
        .AE_LEVEL   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Storage: synchronous write, asynchronous read.
    always @(posedge clk) begin
        if (bus.w_en) mem[bus.w_addr] <= w_data;
    end
    assign r_data = mem[bus.r_addr];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        bus.wr = w;
        bus.rd = r;
        w_data = d;
        #1;
        $display("t=%0t wr=%b rd=%b wdata=%02h head=%02h count=%0d w_addr=%0d r_addr=%0d",
                 $time, w, r, d, r_data, bus.count, bus.w_addr, bus.r_addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},  int'(bus.empty), 1);
        check({tag, "_full"},   int'(bus.full), 0);
        check({tag, "_count"},  int'(bus.count), 0);
        check({tag, "_waddr"},  int'(bus.w_addr), 0);
        check({tag, "_raddr"},  int'(bus.r_addr), 0);
        check({tag, "_ae"},     int'(bus.almost_empty), 1);
        check({tag, "_af"},     int'(bus.almost_full), 0);
        check({tag, "_ovf"},    int'(bus.overflow), 0);
        check({tag, "_unf"},    int'(bus.underflow), 0);
    endtask

    initial begin
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        do_reset();
        tick();
        check_reset_state("rst");

        // Fill: 32 pushes of 0..31.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            check("fill_wen", int'(bus.w_en), 1);
            tick();
            check("fill_count", int'(bus.count), i + 1);
            check("fill_af",    int'(bus.almost_full), (i + 1 >= 28) ? 1 : 0);
            check("fill_ae",    int'(bus.almost_empty), (i + 1 <= 4) ? 1 : 0);
            check("fill_full",  int'(bus.full), (i == 31) ? 1 : 0);
            check("fill_empty", int'(bus.empty), 0);
            check("fill_waddr", int'(bus.w_addr), (i + 1) % 32);
        end

        // Push while full.
        drive(1'b1, 1'b0, 8'hEE);
        check("ovf_wen", int'(bus.w_en), 0);
        tick();
        check("ovf_pulse", int'(bus.overflow), 1);
        check("ovf_count", int'(bus.count), 32);
        check("ovf_waddr", int'(bus.w_addr), 0);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("ovf_clear", int'(bus.overflow), 0);

        // Drain: head must be 0..31 in order.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            check("drain_head", int'(r_data), i);
            tick();
            check("drain_count", int'(bus.count), 31 - i);
            check("drain_empty", int'(bus.empty), (i == 31) ? 1 : 0);
            check("drain_full",  int'(bus.full), 0);
            check("drain_raddr", int'(bus.r_addr), (i + 1) % 32);
        end

        // Pop while empty.
        drive(1'b0, 1'b1, 8'h00);
        tick();
        check("unf_pulse", int'(bus.underflow), 1);
        check("unf_raddr", int'(bus.r_addr), 0);
        check("unf_count", int'(bus.count), 0);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("unf_clear", int'(bus.underflow), 0);

        // wr+rd while empty: write only, underflow flagged.
        drive(1'b1, 1'b1, 8'hA0);
        check("wrrd_empty_wen", int'(bus.w_en), 1);
        tick();
        check("wrrd_empty_count", int'(bus.count), 1);
        check("wrrd_empty_unf",   int'(bus.underflow), 1);
        check("wrrd_empty_empty", int'(bus.empty), 0);
        check("wrrd_empty_waddr", int'(bus.w_addr), 1);
        check("wrrd_empty_raddr", int'(bus.r_addr), 0);
        drive(1'b0, 1'b1, 8'h00);
        check("wrrd_empty_head", int'(r_data), 8'hA0);
        tick();
        check("wrrd_empty_drain", int'(bus.count), 0);

        // wr+rd at count 5 (pointers at 1/1 before preload).
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'(8'h50 + i));
            tick();
        end
        check("c5_pre_count", int'(bus.count), 5);
        drive(1'b1, 1'b1, 8'h55);
        check("c5_head", int'(r_data), 8'h50);
        tick();
        check("c5_count", int'(bus.count), 5);
        check("c5_waddr", int'(bus.w_addr), 7);
        check("c5_raddr", int'(bus.r_addr), 2);

        // Top up to full, then wr+rd: read only, overflow flagged.
        for (int i = 0; i < 27; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            tick();
        end
        check("c32_full", int'(bus.full), 1);
        drive(1'b1, 1'b1, 8'hCC);
        check("wrrd_full_wen", int'(bus.w_en), 0);
        tick();
        check("wrrd_full_count", int'(bus.count), 31);
        check("wrrd_full_ovf",   int'(bus.overflow), 1);
        check("wrrd_full_full",  int'(bus.full), 0);
        check("wrrd_full_waddr", int'(bus.w_addr), 2);
        check("wrrd_full_raddr", int'(bus.r_addr), 3);

        // Steady stream across pointer wrap.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'(k));
            tick();
        end
        for (int k = 3; k < 103; k++) begin
            drive(1'b1, 1'b1, 8'(k));
            check("stream_head", int'(r_data), k - 3);
            tick();
            check("stream_count", int'(bus.count), 3);
            check("stream_waddr", int'(bus.w_addr), (k + 1) % 32);
            check("stream_raddr", int'(bus.r_addr), (k - 2) % 32);
        end

        // Reset mid-burst at count 17 with wr and rd both asserted.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 8'(8'h30 + i));
            tick();
        end
        check("mid_pre_count", int'(bus.count), 17);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 8'h99);
        tick();
        check_reset_state("mid_rst");
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h77);
        check("post_rst_waddr", int'(bus.w_addr), 0);
        check("post_rst_wen",   int'(bus.w_en), 1);
        tick();
        check("post_rst_count", int'(bus.count), 1);
        check("post_rst_head",  int'(r_data), 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
